// File: rtl/sram_rot_pkg.sv
// Shared types and constants for the SRAM bank rotator.
package sram_rot_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  localparam int unsigned NUM_BANKS_MIN = 2;
  localparam int unsigned NUM_BANKS_MAX = 8;

  // Round-robin successor of bank index cur in a ring of n banks.
  function automatic int unsigned next_bank(int unsigned cur, int unsigned n);
    return (cur + 1 == n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/sram_bank_state.sv
// Per-bank ownership state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY,
// plus DRAINING -> FILLING when a freed bank is handed straight to a stalled writer.
module sram_bank_state
  import sram_rot_pkg::*;
#(
  parameter bit RESET_FILLING = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go_filling,
  input  logic        go_full,
  input  logic        go_draining,
  input  logic        go_empty,
  output bank_state_t state
);

  bank_state_t state_q, state_d;

  // Next-state: only legal transitions out of the current state are honoured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:    if (go_filling) state_d = FILLING;
      FILLING:  if (go_full) state_d = FULL;
      FULL:     if (go_draining) state_d = DRAINING;
      DRAINING: begin
        if (go_filling)    state_d = FILLING;
        else if (go_empty) state_d = EMPTY;
      end
      default:  state_d = state_q;
    endcase
  end

  // State register; bank 0 comes out of reset already owned by the writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_FILLING ? FILLING : EMPTY;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/sram_bank_rotator.sv
// Ping-pong / multi-bank SRAM rotator: writer fills banks round-robin, reader
// drains them in the same order. Optional macro SRAM_ROT_RDATA_REG_EN registers
// sram_rdata/sram_ready (one cycle latency); default is combinational.
module sram_bank_rotator
  import sram_rot_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned DATA_W    = 128,
  localparam int unsigned BANK_W   = ($clog2(NUM_BANKS) > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        core_done,
  input  logic                        drain_done,
  input  logic                        sram_wen,
  input  logic                        sram_ren,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
  input  logic [NUM_BANKS-1:0]        bank_ready,
  output logic [NUM_BANKS-1:0]        bank_wen,
  output logic [NUM_BANKS-1:0]        bank_ren,
  output logic [DATA_W-1:0]           sram_rdata,
  output logic                        sram_ready,
  output logic [BANK_W-1:0]           fill_bank,
  output logic [BANK_W-1:0]           drain_bank,
  output logic                        drain_valid,
  output logic                        core_stall,
  output logic                        overflow
);

  if (NUM_BANKS < NUM_BANKS_MIN || NUM_BANKS > NUM_BANKS_MAX) begin : g_bad_num_banks
    $error("sram_bank_rotator: NUM_BANKS out of legal range");
  end

  logic [BANK_W-1:0]    fill_bank_q, fill_bank_d, drain_bank_q, drain_bank_d, nxt_fill;
  logic                 drain_valid_q, drain_valid_d, core_stall_q, core_stall_d;
  logic                 overflow_q, overflow_d;
  logic [NUM_BANKS-1:0] fill_oh, drain_oh, nxt_oh, is_empty, is_full;
  logic [NUM_BANKS-1:0] go_filling, go_full, go_draining, go_empty;
  logic                 drain_free, drain_take, fill_accept, next_free, stall_resolve;
  logic [DATA_W-1:0]    rdata_sel;
  logic                 ready_sel;
  bank_state_t          bank_st [NUM_BANKS];

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    sram_bank_state #(.RESET_FILLING(i == 0)) u_state (
      .clk         (clk),
      .rst_n       (rst_n),
      .go_filling  (go_filling[i]),
      .go_full     (go_full[i]),
      .go_draining (go_draining[i]),
      .go_empty    (go_empty[i]),
      .state       (bank_st[i])
    );
    assign is_empty[i] = (bank_st[i] == EMPTY);
    assign is_full[i]  = (bank_st[i] == FULL);
  end

  // One-hot decode of the bank pointers (loop compare keeps non-power-of-2 rings safe).
  always_comb begin
    nxt_fill = BANK_W'(next_bank(32'(fill_bank_q), NUM_BANKS));
    fill_oh  = '0;
    drain_oh = '0;
    nxt_oh   = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      fill_oh[i]  = (fill_bank_q == BANK_W'(i));
      drain_oh[i] = (drain_bank_q == BANK_W'(i));
      nxt_oh[i]   = (nxt_fill == BANK_W'(i));
    end
  end

  // Rotation control: a bank freed by drain_done this cycle counts as EMPTY
  // for the writer, so simultaneous done pulses never stall or overflow.
  always_comb begin
    drain_free    = drain_valid_q & drain_done;
    drain_take    = ~drain_valid_q & |(is_full & drain_oh);
    fill_accept   = core_done & ~core_stall_q;
    next_free     = |(is_empty & nxt_oh) | (drain_free & |(drain_oh & nxt_oh));
    stall_resolve = core_stall_q & drain_free & |(drain_oh & fill_oh);

    go_full     = {NUM_BANKS{fill_accept}} & fill_oh;
    go_filling  = ({NUM_BANKS{fill_accept & next_free}} & nxt_oh)
                | ({NUM_BANKS{stall_resolve}} & fill_oh);
    go_draining = {NUM_BANKS{drain_take}} & drain_oh;
    go_empty    = {NUM_BANKS{drain_free}} & drain_oh;

    fill_bank_d   = fill_accept ? nxt_fill : fill_bank_q;
    core_stall_d  = fill_accept ? ~next_free : (stall_resolve ? 1'b0 : core_stall_q);
    overflow_d    = overflow_q | (core_done & core_stall_q & ~stall_resolve);
    drain_bank_d  = drain_free ? BANK_W'(next_bank(32'(drain_bank_q), NUM_BANKS)) : drain_bank_q;
    drain_valid_d = drain_free ? 1'b0 : (drain_take ? 1'b1 : drain_valid_q);
  end

  // Pointer and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_bank_q   <= '0;
      drain_bank_q  <= '0;
      drain_valid_q <= 1'b0;
      core_stall_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      fill_bank_q   <= fill_bank_d;
      drain_bank_q  <= drain_bank_d;
      drain_valid_q <= drain_valid_d;
      core_stall_q  <= core_stall_d;
      overflow_q    <= overflow_d;
    end
  end

  // Enable steering and read-data select from the current pointers.
  always_comb begin
    bank_wen  = fill_oh & {NUM_BANKS{sram_wen & ~core_stall_q}};
    bank_ren  = drain_oh & {NUM_BANKS{sram_ren}};
    rdata_sel = '0;
    ready_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (drain_oh[i]) begin
        rdata_sel = bank_rdata[i*DATA_W +: DATA_W];
        ready_sel = bank_ready[i];
      end
    end
  end

`ifdef SRAM_ROT_RDATA_REG_EN
  logic [DATA_W-1:0] sram_rdata_q;
  logic              sram_ready_q;

  // Read return register; source bank is the one selected in the request cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_rdata_q <= '0;
      sram_ready_q <= 1'b0;
    end else begin
      sram_rdata_q <= rdata_sel;
      sram_ready_q <= ready_sel;
    end
  end

  assign sram_rdata = sram_rdata_q;
  assign sram_ready = sram_ready_q;
`else
  assign sram_rdata = rdata_sel;
  assign sram_ready = ready_sel;
`endif

  assign fill_bank   = fill_bank_q;
  assign drain_bank  = drain_bank_q;
  assign drain_valid = drain_valid_q;
  assign core_stall  = core_stall_q;
  assign overflow    = overflow_q;

endmodule
